// File: rtl/ide_arb_pkg.sv
// Shared types and constants for the two-port IDE arbiter.
package ide_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd12_000_000;

  // Write wins when a requester raises both rd and wr, matching the engine.
  function automatic op_t req_op(input logic wr);
    return wr ? OP_WR : OP_RD;
  endfunction

endpackage

// File: rtl/ide_rr_pick.sv
// Combinational 2-way round-robin selector; on a tie the port not served last wins.
module ide_rr_pick (
  input  logic pend0,
  input  logic pend1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = pend0 | pend1;
  assign winner = (pend0 & pend1) ? ~last : pend1;

endmodule

// File: rtl/ide_arbiter.sv
// Shares one ide_disk engine between two requesters and sequences each transfer.
// Optional watchdog abort is enabled by defining IDE_ARB_TIMEOUT_EN.
module ide_arbiter
  import ide_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [23:0] req0_lba,
  output logic        req0_done,
  output logic        req0_err,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [23:0] req1_lba,
  output logic        req1_done,
  output logic        req1_err,
  output logic [23:0] ide_lba,
  output logic        ide_read_req,
  output logic        ide_write_req,
  input  logic        ide_done,
  input  logic        ide_error,
  output logic        grant,
  output logic        busy,
  output logic        ide_abort
);

  state_t state;
  op_t    op;
  logic   last;
  logic   pick_valid;
  logic   pick_winner;

  ide_rr_pick u_pick (
    .pend0  (req0_rd | req0_wr),
    .pend1  (req1_rd | req1_wr),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign busy = (state != IDLE);

`ifdef IDE_ARB_TIMEOUT_EN
  logic [23:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign ide_abort      = 1'b0;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, as real flops do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      op            <= OP_RD;
      last          <= 1'b1;
      grant         <= 1'b0;
      ide_lba       <= '0;
      ide_read_req  <= 1'b0;
      ide_write_req <= 1'b0;
      req0_done     <= 1'b0;
      req0_err      <= 1'b0;
      req1_done     <= 1'b0;
      req1_err      <= 1'b0;
`ifdef IDE_ARB_TIMEOUT_EN
      wd_cnt        <= '0;
      ide_abort     <= 1'b0;
`endif
    end else begin
      req0_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_done <= 1'b0;
      req1_err  <= 1'b0;
`ifdef IDE_ARB_TIMEOUT_EN
      ide_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_winner;
            last    <= pick_winner;
            ide_lba <= pick_winner ? req1_lba : req0_lba;
            op      <= pick_winner ? req_op(req1_wr) : req_op(req0_wr);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          ide_read_req  <= (op == OP_RD);
          ide_write_req <= (op == OP_WR);
`ifdef IDE_ARB_TIMEOUT_EN
          wd_cnt        <= '0;
`endif
          state         <= WAIT;
        end
        WAIT: begin
          if (ide_done) begin
            ide_read_req  <= 1'b0;
            ide_write_req <= 1'b0;
            req0_done     <= ~grant;
            req0_err      <= ~grant & ide_error;
            req1_done     <= grant;
            req1_err      <= grant & ide_error;
            state         <= RELEASE;
          end
`ifdef IDE_ARB_TIMEOUT_EN
          // Engine is hung: abort it and report the transfer as failed.
          else if (wd_cnt == TIMEOUT_CYCLES - 24'd1) begin
            ide_abort     <= 1'b1;
            ide_read_req  <= 1'b0;
            ide_write_req <= 1'b0;
            req0_done     <= ~grant;
            req0_err      <= ~grant;
            req1_done     <= grant;
            req1_err      <= grant;
            state         <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
`endif
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ide_arbiter.sv
// Directed, table-driven bench for ide_arbiter plus hand-written corner sequences.
module tb_ide_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic [23:0] req0_lba, req1_lba;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [23:0] ide_lba;
  logic        ide_read_req, ide_write_req;
  logic        ide_done, ide_error;
  logic        grant, busy, ide_abort;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ide_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_rd       (req0_rd),
    .req0_wr       (req0_wr),
    .req0_lba      (req0_lba),
    .req0_done     (req0_done),
    .req0_err      (req0_err),
    .req1_rd       (req1_rd),
    .req1_wr       (req1_wr),
    .req1_lba      (req1_lba),
    .req1_done     (req1_done),
    .req1_err      (req1_err),
    .ide_lba       (ide_lba),
    .ide_read_req  (ide_read_req),
    .ide_write_req (ide_write_req),
    .ide_done      (ide_done),
    .ide_error     (ide_error),
    .grant         (grant),
    .busy          (busy),
    .ide_abort     (ide_abort)
  );

  typedef struct {
    logic        rd0, wr0;
    logic [23:0] lba0;
    logic        rd1, wr1;
    logic [23:0] lba1;
    logic        err;
    logic        exp_grant;
    logic        exp_wr;
    logic [23:0] exp_lba;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    req0_rd = 0; req0_wr = 0; req1_rd = 0; req1_wr = 0;
  endtask

  // Returns the number of negedges until a request line is seen (bounded).
  task automatic wait_req(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ide_read_req || ide_write_req) && lat < 12);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lba"},  ide_lba, 0);
    check({tag, "_reqs"}, {ide_read_req, ide_write_req}, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, {req0_done, req0_err, req1_done, req1_err, ide_abort}, 0);
  endtask

  // One full transfer, entered and left at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic [23:0] lba_keep;
    req0_rd = v.rd0; req0_wr = v.wr0; req0_lba = v.lba0;
    req1_rd = v.rd1; req1_wr = v.wr1; req1_lba = v.lba1;
    wait_req(lat);
    check($sformatf("v%0d_latency", idx), lat, 2);
    check($sformatf("v%0d_grant", idx), grant, v.exp_grant);
    check($sformatf("v%0d_lba", idx), ide_lba, v.exp_lba);
    check($sformatf("v%0d_op", idx), {ide_read_req, ide_write_req}, {~v.exp_wr, v.exp_wr});
    check($sformatf("v%0d_busy", idx), busy, 1);
    lba_keep = ide_lba;
    // The owner rewrites its lba and swaps its op; the transfer must not notice.
    if (v.exp_grant) begin
      req1_lba = req1_lba ^ 24'h000030;
      {req1_rd, req1_wr} = {req1_wr, req1_rd};
    end else begin
      req0_lba = req0_lba ^ 24'h000030;
      {req0_rd, req0_wr} = {req0_wr, req0_rd};
    end
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_lba_hold", idx), ide_lba, lba_keep);
    check($sformatf("v%0d_op_hold", idx), {ide_read_req, ide_write_req}, {~v.exp_wr, v.exp_wr});
    ide_done = 1; ide_error = v.err;
    @(negedge clk);
    ide_done = 0; ide_error = 0;
    check($sformatf("v%0d_done", idx), {req0_done, req1_done}, v.exp_grant ? 2'b01 : 2'b10);
    check($sformatf("v%0d_err", idx), {req0_err, req1_err}, v.exp_grant ? {1'b0, v.err} : {v.err, 1'b0});
    check($sformatf("v%0d_req_low", idx), {ide_read_req, ide_write_req}, 0);
    clear_reqs();
    @(negedge clk);
    check($sformatf("v%0d_idle", idx), {busy, req0_done, req1_done}, 0);
  endtask

  initial begin
    int lat;
    int early;
    vec_t v_both;

    reset = 1; clear_reqs(); req0_lba = 0; req1_lba = 0; ide_done = 0; ide_error = 0;
    v_both = '{rd0:1, wr0:0, lba0:24'h0000A0, rd1:0, wr1:1, lba1:24'h0000B1,
               err:0, exp_grant:0, exp_wr:0, exp_lba:24'h0000A0};
    vecs[0] = v_both;
    vecs[1] = v_both; vecs[1].exp_grant = 1; vecs[1].exp_wr = 1; vecs[1].exp_lba = 24'h0000B1;
    vecs[2] = v_both;
    vecs[3] = vecs[1];
    vecs[4] = '{rd0:0, wr0:0, lba0:24'h0, rd1:1, wr1:1, lba1:24'h000777,
                err:0, exp_grant:1, exp_wr:1, exp_lba:24'h000777};
    vecs[5] = '{rd0:1, wr0:0, lba0:24'h000123, rd1:0, wr1:0, lba1:24'h0,
                err:0, exp_grant:0, exp_wr:0, exp_lba:24'h000123};
    vecs[6] = '{rd0:0, wr0:1, lba0:24'h000010, rd1:0, wr1:0, lba1:24'h0,
                err:1, exp_grant:0, exp_wr:1, exp_lba:24'h000010};
    vecs[7] = '{rd0:0, wr0:0, lba0:24'h0, rd1:1, wr1:0, lba1:24'h0000FF,
                err:0, exp_grant:1, exp_wr:0, exp_lba:24'h0000FF};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Owner drops its request mid-transfer; the other port asks during WAIT.
    req0_rd = 1; req0_lba = 24'h000055;
    wait_req(lat);
    check("drop_grant", grant, 0);
    req0_rd = 0; req1_wr = 1; req1_lba = 24'h0000C3;
    repeat (3) @(negedge clk);
    check("wait_no_regrant", {grant, ide_lba}, {1'b0, 24'h000055});
    check("drop_req_held", ide_read_req, 1);
    ide_done = 1;
    @(negedge clk);
    ide_done = 0;
    check("drop_done", {req0_done, req0_err, req1_done}, 3'b100);
    lat = 1;
    while (!(ide_read_req || ide_write_req) && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("turnaround", lat, 4);
    check("turn_owner", {grant, ide_lba, ide_write_req}, {1'b1, 24'h0000C3, 1'b1});

    // Asynchronous reset in the middle of WAIT.
    #1 reset = 1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    reset = 0;
    req0_rd = 1; req0_lba = 24'h000044; req1_wr = 1; req1_lba = 24'h000099;
    wait_req(lat);
    check("rst_tie_grant", {grant, ide_lba, ide_read_req}, {1'b0, 24'h000044, 1'b1});
    ide_done = 1;
    @(negedge clk);
    ide_done = 0; clear_reqs();
    check("rst_tie_done", {req0_done, req1_done}, 2'b10);
    @(negedge clk);

`ifdef IDE_ARB_TIMEOUT_EN
    // No ide_done: abort on the 16th WAIT cycle.
    req0_rd = 1; req0_lba = 24'h000200;
    wait_req(lat);
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (ide_abort || req0_done) early = 1;
    end
    check("to_not_early", early, 0);
    @(negedge clk);
    check("to_abort", {ide_abort, req0_done, req0_err, ide_read_req}, 4'b1110);
    clear_reqs();
    @(negedge clk);
    check("to_abort_pulse", {ide_abort, busy}, 0);
    // ide_done coincident with expiry wins.
    req0_rd = 1;
    wait_req(lat);
    repeat (15) @(negedge clk);
    ide_done = 1;
    @(negedge clk);
    ide_done = 0; clear_reqs();
    check("to_done_wins", {ide_abort, req0_done, req0_err}, 3'b010);
    @(negedge clk);
`else
    // Without the watchdog, WAIT holds until ide_done however long it takes.
    req0_rd = 1; req0_lba = 24'h000200;
    wait_req(lat);
    early = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ide_abort || req0_done || !ide_read_req) early = 1;
    end
    check("no_wd_hold", early, 0);
    ide_done = 1;
    @(negedge clk);
    ide_done = 0; clear_reqs();
    check("no_wd_done", {ide_abort, req0_done, req0_err}, 3'b010);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ide_arbiter.md
# ide_arbiter

Two-port arbiter and sequencer for the single-block IDE disk engine. It shares one `ide_disk` instance between two requesters, for example a DF32/RF08 emulation and a TC08 emulation. It latches the winning requester's LBA and operation and holds the engine's request lines stable for the whole transfer. It then returns a per-requester done/error pulse, and exports `grant` so the top level can steer the 256-word buffer port to the owner.

## Interface
- `TIMEOUT_CYCLES`, default 24'd12_000_000: watchdog limit in clk cycles; used only with `IDE_ARB_TIMEOUT_EN`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req0_rd` / `req0_wr` in 1/1: requester 0 read/write request, level; held until `req0_done`.
- `req0_lba` in 24: requester 0 block address.
- `req0_done` / `req0_err` out 1/1: one-cycle completion pulse, and the error flag valid with it.
- `req1_rd`, `req1_wr`, `req1_lba`, `req1_done`, `req1_err`: same as requester 0, for requester 1.
- `ide_lba` out 24: to `ide_disk.ide_lba`, registered.
- `ide_read_req` / `ide_write_req` out 1/1: to the engine, registered levels.
- `ide_done` / `ide_error` in 1/1: from the engine; `ide_done` is a one-cycle pulse.
- `grant` out 1: owner of the current or last transfer (0 or 1); buffer mux select.
- `busy` out 1: high in every state except IDLE.
- `ide_abort` out 1: one-cycle pulse on watchdog expiry, ORed into the engine's reset; tied 0 without the macro.

## Operation
- A requester is pending when its rd or wr is high. If both are high, write wins (same priority as the engine).
- Round-robin uses a `last` register. A single pending requester wins outright. If both are pending, the winner is `!last`. `last` is updated to the winner at grant.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - If any requester is pending: latch `grant`, `ide_lba` ← that requester's lba, and op ← rd/wr; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: drive `ide_read_req` or `ide_write_req` high from the latched op (the other stays low); go to WAIT.
- WAIT:
  - Hold the request lines and `ide_lba` constant.
  - On `ide_done`: clear both request lines; pulse `reqN_done` for the granted N, with `reqN_err` = `ide_error` sampled in the `ide_done` cycle; go to RELEASE.
- RELEASE: one-cycle gap so the engine returns to its ready state with the request low; go to IDLE.
- Requester rule: a requester clears rd/wr on the clock edge at which it samples its done pulse. The arbiter never re-grants on a stale request.
- Changes to a granted requester's lba or op after grant are ignored.
- A granted requester that drops its request mid-transfer still receives done.
- Requests arriving during ISSUE, WAIT or RELEASE wait for IDLE.
- `reset` (asynchronous, any state):
  - State → IDLE; `last` → 1, so requester 0 wins the first tie.
  - All outputs → 0: `ide_lba` = 0, `grant` = 0, `busy` = 0, all done/err/req/abort = 0.
  - Watchdog counter → 0.

## Timing
- Latency from the first IDLE cycle with a pending request to `ide_*_req` high: 2 clocks (IDLE→ISSUE edge, then ISSUE→WAIT edge).
- `reqN_done` / `reqN_err` are registered; they are high during the RELEASE cycle, which is the cycle after `ide_done`.
- `ide_*_req` are low from the RELEASE cycle onward.
- Back-to-back turnaround from `ide_done` to the next `ide_*_req` high: 4 clocks (done→RELEASE, →IDLE, →ISSUE, →WAIT).

## Configuration
- `IDE_ARB_TIMEOUT_EN` defined:
  - A 24-bit counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES - 1` without `ide_done`: pulse `ide_abort`, clear the request lines, and pulse done with err=1 for the owner; go to RELEASE.
  - If `ide_done` and expiry occur in the same cycle, `ide_done` wins and there is no abort.
- `IDE_ARB_TIMEOUT_EN` undefined: no counter; `ide_abort` is constant 0; WAIT exits only on `ide_done`.

## Structure
- Package `ide_arb_pkg`:
  - 2-bit state encoding: IDLE=0, ISSUE=1, WAIT=2, RELEASE=3.
  - 1-bit op encoding: RD=0, WR=1.
  - Default `TIMEOUT_CYCLES` constant.
- Sub-module `ide_rr_pick`: combinational 2-way round-robin selector.
  - Inputs: pend0, pend1, last.
  - Outputs: valid, winner.

## Test plan
- Requester 0 read, lba 24'h000123 → `ide_read_req` high 2 clocks later with `ide_lba` = 000123 and `grant` = 0; inject `ide_done` → `req0_done` one cycle, `req0_err` = 0, `ide_read_req` low.
- Both requesters pending at once, 0 read / 1 write → order 0, 1, 0, 1 over four transfers; each transfer's `ide_lba` and op match its owner.
- `req1_rd` and `req1_wr` both high → `ide_write_req` high, `ide_read_req` low.
- Granted requester changes lba 000010→000020 during WAIT → `ide_lba` stays 000010; `ide_error` = 1 with `ide_done` → `req_err` = 1.
- With `IDE_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, no `ide_done` → `ide_abort` and `req0_done` + `req0_err` on the 16th WAIT cycle; `ide_done` coincident with expiry → no abort.
- `reset` asserted mid-WAIT → all outputs 0 immediately (asynchronous); after release a tie goes to requester 0.
